intlv_commutator: RTL and testbench
===================================

// Module: intlv_commutator
// PURPOSE
// - Input commutator/scheduler for the convolutional byte interleaver. Takes one framed byte stream and
//   assigns each byte to one delay branch in round-robin order. Branch 0 is the zero-delay pass-through.
//   Branch i has a delay of i*DEPTH_UNIT.
// - Sits between the framer and the branch delay lines.
// - Drives branch select, one-hot shift enable and the branch delay value. Keeps frame alignment on the sync byte.
// PARAMETERS
// - NUM_BRANCH  12     number of interleaver branches (index 0..NUM_BRANCH-1)
// - DEPTH_UNIT  17     delay increment per branch, in bytes
// - FRAME_LEN   204    bytes per frame; must be a multiple of NUM_BRANCH
// - DATA_W      8      byte width
// PORTS
// - clk        in   1            rising-edge clock
// - reset      in   1            synchronous, active-low reset
// - in_data    in   DATA_W       input byte
// - in_valid   in   1            in_data valid
// - in_sof     in   1            start of frame; qualified by in_valid
// - in_ready   out  1            block accepts a byte this cycle
// - br_data    out  DATA_W       byte to the branch delay lines (registered)
// - br_sel     out  4            branch index of br_data (registered)
// - br_en      out  NUM_BRANCH   one-hot shift enable; nonzero only when out_valid && out_ready
// - br_delay   out  8            br_sel*DEPTH_UNIT, registered alongside br_sel
// - out_valid  out  1            br_data/br_sel/br_delay hold a valid byte
// - out_ready  in   1            branch side can take the byte
// - frame_err  out  1            one-cycle pulse on a frame alignment error
// - byte_cnt   out  8            position in frame of the last accepted byte
// BEHAVIOUR
// - Reset: while reset==0 at a clk edge, state=IDLE and every registered output clears to 0. in_ready=0.
//   br_en=0. A held output byte is discarded, even mid-frame.
// - Handshake: in_ready = running && (!out_valid || out_ready). running means not in reset.
//   A byte is accepted when in_valid && in_ready.
// - Output stage: single register stage, 1-cycle latency. Outputs hold stable while out_valid && !out_ready.
// - br_en = out_valid && out_ready ? (1<<br_sel) : 0. This is combinational from the registers.
// - FSM state IDLE: accepted bytes with in_sof=0 are dropped, with no output and no count.
//   An accepted byte with in_sof=1 is output on branch 0, byte_cnt=0, and the FSM goes to RUN.
// - FSM state RUN: each accepted byte goes to branch idx. idx increments and wraps NUM_BRANCH-1 -> 0.
//   byte_cnt increments and wraps FRAME_LEN-1 -> 0. Because FRAME_LEN % NUM_BRANCH == 0, idx==0 at every frame start.
// - Early SOF: in RUN, an accepted in_sof=1 with expected byte_cnt != 0 pulses frame_err.
//   Resync: the byte is output on branch 0, byte_cnt=0, and idx restarts at 1.
// - Missing SOF: in RUN, an accepted in_sof=0 with expected byte_cnt == 0 pulses frame_err.
//   The stream keeps running: the byte goes to branch 0 with byte_cnt 0.
// - No accepted byte: idx, byte_cnt and state are unchanged.
// - frame_err: asserted for exactly the cycle after the offending accept. Otherwise 0.
// - Widths: br_delay = br_sel*DEPTH_UNIT truncated to 8 bits. The defaults give a maximum of 187, so no truncation.
//   br_sel is zero-extended to 4 bits.
// TESTING
// - Reset low 3 cycles, then high -> in_ready=1, out_valid=0, br_en=0, all outputs 0 during reset.
// - IDLE with bytes 0x11,0x22 (sof=0), then 0x47 (sof=1), out_ready=1:
//   -> only 0x47 output, br_sel=0, br_delay=0, byte_cnt=0.
// - 204-byte frame with SOF on byte 0 then a second frame, out_ready=1:
//   -> br_sel cycles 0..11 seventeen times, br_delay=17*br_sel, byte_cnt 0..203, no frame_err.
// - SOF at byte 50 -> frame_err pulse 1 cycle, that byte on br_sel=0, byte_cnt=0, next byte on br_sel=1.
// - Byte 204 without SOF -> frame_err pulse, byte on br_sel=0, byte_cnt=0, stream continues.
// - out_ready=0 for 5 cycles mid-frame -> outputs hold, br_en=0, in_ready=0, no byte lost or duplicated.
//   Reset asserted during the stall -> IDLE, out_valid=0.

Source files
------------

// File: rtl/intlv_commutator.sv
// rtl/intlv_commutator.sv - round-robin input commutator for the convolutional byte interleaver
module intlv_commutator #(
  parameter int NUM_BRANCH = 12,
  parameter int DEPTH_UNIT = 17,
  parameter int FRAME_LEN  = 204,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     br_data,
  output logic [3:0]            br_sel,
  output logic [NUM_BRANCH-1:0] br_en,
  output logic [7:0]            br_delay,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err,
  output logic [7:0]            byte_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_BRANCH - 1);
  localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);
  localparam logic [7:0] UNIT_8   = 8'(DEPTH_UNIT);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_idx;
  logic [3:0]            w_idx_nxt;
  logic [7:0]            r_exp_cnt;
  logic [7:0]            w_cnt_nxt;

  logic                  w_accept;
  logic                  w_emit;
  logic                  w_err;
  logic [3:0]            w_sel;
  logic [7:0]            w_cnt;
  logic [7:0]            w_delay;
  logic [NUM_BRANCH-1:0] w_one;

  logic [DATA_W-1:0]     r_data;
  logic [3:0]            r_sel;
  logic [7:0]            r_delay;
  logic [7:0]            r_byte_cnt;
  logic                  r_valid;
  logic                  r_frame_err;

  // Accept only out of reset and when the single output slot is free or draining.
  assign in_ready = reset && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  assign w_one   = {{(NUM_BRANCH-1){1'b0}}, 1'b1};
  assign w_delay = {4'b0000, w_sel} * UNIT_8;

  // Next-state and branch assignment for the accepted byte; a sync byte always
  // forces branch 0 / position 0, and the error flag marks any misplaced sync.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_exp_cnt;
    w_emit      = 1'b0;
    w_err       = 1'b0;
    w_sel       = r_idx;
    w_cnt       = r_exp_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && in_sof) begin
          w_emit      = 1'b1;
          w_sel       = 4'd0;
          w_cnt       = 8'd0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_emit = 1'b1;
          w_err  = in_sof != (r_exp_cnt == 8'd0);
          if (in_sof) begin
            w_sel = 4'd0;
            w_cnt = 8'd0;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_emit) begin
      w_idx_nxt = (w_sel == LAST_IDX) ? 4'd0 : w_sel + 4'd1;
      w_cnt_nxt = (w_cnt == LAST_CNT) ? 8'd0 : w_cnt + 8'd1;
    end
  end

  // FSM state and round-robin position registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= 4'd0;
      r_exp_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_exp_cnt <= w_cnt_nxt;
    end
  end

  // Output register: load on emit, release when the branch side takes the byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data     <= '0;
      r_sel      <= 4'd0;
      r_delay    <= 8'd0;
      r_byte_cnt <= 8'd0;
      r_valid    <= 1'b0;
    end else if (w_emit) begin
      r_data     <= in_data;
      r_sel      <= w_sel;
      r_delay    <= w_delay;
      r_byte_cnt <= w_cnt;
      r_valid    <= 1'b1;
    end else if (out_ready) begin
      r_valid    <= 1'b0;
    end
  end

  // Alignment error is a single-cycle pulse following the offending accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
    end
  end

  assign br_data   = r_data;
  assign br_sel    = r_sel;
  assign br_delay  = r_delay;
  assign byte_cnt  = r_byte_cnt;
  assign out_valid = r_valid;
  assign frame_err = r_frame_err;
  assign br_en     = (r_valid && out_ready) ? (w_one << r_sel) : '0;

endmodule

// File: tb/tb_intlv_commutator.sv
// tb/tb_intlv_commutator.sv - scoreboard bench for intlv_commutator
module tb_intlv_commutator;
  localparam int NB = 12;
  localparam int DU = 17;
  localparam int FL = 204;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sof;
  logic        in_ready;
  logic [7:0]  br_data;
  logic [3:0]  br_sel;
  logic [NB-1:0] br_en;
  logic [7:0]  br_delay;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;
  logic [7:0]  byte_cnt;

  always #5 clk = ~clk;

  intlv_commutator #(.NUM_BRANCH(NB), .DEPTH_UNIT(DU), .FRAME_LEN(FL), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .br_data(br_data), .br_sel(br_sel), .br_en(br_en),
    .br_delay(br_delay), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .byte_cnt(byte_cnt)
  );

  typedef struct { int data; int sel; int delay; int cnt; } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  bit in_frame = 0;
  int pos = 0;
  bit exp_err = 0;
  bit stall = 0;
  bit rand_rdy = 0;
  bit rand_gap = 0;
  int last_d = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: frame position arithmetic applied to every accepted byte.
  always @(negedge clk) begin
    bit e;
    exp_t x;
    e = 0;
    if (reset && in_valid && in_ready) begin
      if (!in_frame) begin
        if (in_sof) begin
          x = '{int'(in_data), 0, 0, 0};
          q.push_back(x);
          in_frame = 1;
          pos = 1;
        end
      end else begin
        if (in_sof) begin
          e = (pos != 0);
          pos = 0;
        end else begin
          e = (pos == 0);
        end
        x.data  = int'(in_data);
        x.cnt   = pos;
        x.sel   = pos % NB;
        x.delay = (pos % NB) * DU;
        q.push_back(x);
        pos = (pos + 1) % FL;
      end
    end
    exp_err <= e;
  end

  // Monitor: handshake rule, error pulse and in-order output comparison.
  always @(negedge clk) begin
    exp_t x;
    chk("in_ready", int'(in_ready), int'(reset && (!out_valid || out_ready)));
    chk("frame_err", int'(frame_err), int'(exp_err));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got data %0d with no byte expected", br_data);
      end else begin
        x = q.pop_front();
        n_out++;
        chk("br_data", int'(br_data), x.data);
        chk("br_sel", int'(br_sel), x.sel);
        chk("br_delay", int'(br_delay), x.delay);
        chk("byte_cnt", int'(byte_cnt), x.cnt);
        chk("br_en", int'(br_en), 1 << x.sel);
      end
    end else begin
      chk("br_en_idle", int'(br_en), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    out_ready = stall ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    in_data = d;
    in_sof = s;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (acc) last_d = int'(d);
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no accept in %0d cycles, required accept", n);
    end
    if (rand_gap && $urandom_range(0, 3) == 0) tick();
  endtask

  initial begin
    bit s;
    int esel;
    logic [7:0] d;
    reset = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_data = 8'd0;
    out_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_br_en", int'(br_en), 0);
      chk("rst_br_data", int'(br_data), 0);
      chk("rst_br_sel", int'(br_sel), 0);
      chk("rst_br_delay", int'(br_delay), 0);
      chk("rst_byte_cnt", int'(byte_cnt), 0);
      chk("rst_frame_err", int'(frame_err), 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);
    tick();

    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h47, 1'b1);
    tick();
    tick();
    chk("idle_out_count", n_out, 1);

    for (int i = 1; i < FL; i++) send(8'(i), 1'b0);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < FL; i++) send(8'($urandom), i == 0);

    for (int i = 0; i <= 50; i++) send(8'($urandom), (i == 0) || (i == 50));
    repeat (10) send(8'($urandom), 1'b0);

    while (pos != 0) send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b0);
    repeat (5) send(8'($urandom), 1'b0);

    repeat (100) send(8'($urandom), 1'b0);
    esel = ((pos + FL - 1) % FL) % NB;
    stall = 1;
    out_ready = 1'b0;
    d = 8'($urandom);
    in_data = d;
    in_sof = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_br_en", int'(br_en), 0);
      chk("stall_br_data", int'(br_data), last_d);
      chk("stall_br_sel", int'(br_sel), esel);
      tick();
    end
    stall = 0;
    out_ready = 1'b1;
    send(d, 1'b0);
    repeat (20) send(8'($urandom), 1'b0);

    stall = 1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    reset = 1'b0;
    q.delete();
    in_frame = 0;
    pos = 0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_stall_out_valid", int'(out_valid), 0);
    tick();
    reset = 1'b1;
    stall = 0;
    out_ready = 1'b1;

    rand_rdy = 1;
    rand_gap = 1;
    repeat (1500) begin
      if (in_frame) s = (pos == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 49) == 0);
      else s = ($urandom_range(0, 3) == 0);
      send(8'($urandom), s);
    end

    rand_rdy = 0;
    rand_gap = 0;
    repeat (5) tick();
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
